divide_seq: RTL and testbench

DIVIDE_SEQ -- requirements
Module: divide_seq

---
 rtl/divide_seq.sv | 127 ++++++++++++
 tb/tb_divide_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_seq.sv
// Sequential restoring divider: signed/unsigned, one quotient bit per cycle.
// Divide-by-zero shortcuts straight to FIX and returns all-ones / raw dividend.
module divide_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      iter;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   dvsr;
   logic               q_neg;
   logic               r_neg;
   logic               zero_div;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               b_zero;
   logic [2*WIDTH-1:0] shifted;
   logic [2*WIDTH-1:0] step;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;

   always_comb begin
      a_neg  = is_signed & dividend[WIDTH-1];
      b_neg  = is_signed & divisor[WIDTH-1];
      a_mag  = a_neg ? -dividend : dividend;
      b_mag  = b_neg ? -divisor : divisor;
      b_zero = (divisor == '0);
   end

   // The bit shifted out of the top acts as a carry: the partial remainder
   // can exceed WIDTH bits for one step when the divisor is large.
   always_comb begin
      shifted = {acc[2*WIDTH-2:0], 1'b0};
      step    = shifted;
      if (acc[2*WIDTH-1] || (shifted[2*WIDTH-1:WIDTH] >= dvsr)) begin
         step[2*WIDTH-1:WIDTH] = shifted[2*WIDTH-1:WIDTH] - dvsr;
         step[0]               = 1'b1;
      end
   end

   assign q_mag = acc[WIDTH-1:0];
   assign r_mag = acc[2*WIDTH-1:WIDTH];
   assign busy  = (state == RUN) || (state == FIX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         iter        <= '0;
         acc         <= '0;
         dvsr        <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         zero_div    <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            iter  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     q_neg    <= a_neg ^ b_neg;
                     r_neg    <= a_neg;
                     zero_div <= b_zero;
                     dvsr     <= b_mag;
                     // Zero divisor keeps the raw dividend for the remainder.
                     acc      <= {{WIDTH{1'b0}}, (b_zero ? dividend : a_mag)};
                     iter     <= '0;
                     state    <= b_zero ? FIX : RUN;
                  end
               end
               RUN: begin
                  acc <= step;
                  if (iter == LAST) begin
                     iter  <= '0;
                     state <= FIX;
                  end else begin
                     iter <= iter + CW'(1);
                  end
               end
               FIX: begin
                  state       <= IDLE;
                  done        <= 1'b1;
                  div_by_zero <= zero_div;
                  if (zero_div) begin
                     quotient  <= '1;
                     remainder <= q_mag;
                  end else begin
                     quotient  <= q_neg ? -q_mag : q_mag;
                     remainder <= r_neg ? -r_mag : r_mag;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_divide_seq.sv
// Scoreboard bench for divide_seq at WIDTH=32 and WIDTH=8 side by side,
// checked against a plain-arithmetic reference model.
module tb_divide_seq;

   typedef struct packed {
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, start, flush, sgn;
   logic [1:0][63:0] av, bv;
   logic             busy32, done32, dz32, busy8, done8, dz8;
   logic [31:0]      q32, r32;
   logic [7:0]       q8, r8;

   int   checks = 0;
   int   failures = 0;
   int   done_cnt [2];
   exp_t sb0[$];
   exp_t sb1[$];
   exp_t last_r [2];

   divide_seq #(.WIDTH(32)) u_d32 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .flush(flush[0]), .is_signed(sgn[0]),
      .dividend(av[0][31:0]), .divisor(bv[0][31:0]), .busy(busy32), .done(done32),
      .quotient(q32), .remainder(r32), .div_by_zero(dz32)
   );

   divide_seq #(.WIDTH(8)) u_d8 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .flush(flush[1]), .is_signed(sgn[1]),
      .dividend(av[1][7:0]), .divisor(bv[1][7:0]), .busy(busy8), .done(done8),
      .quotient(q8), .remainder(r8), .div_by_zero(dz8)
   );

   function automatic logic f_busy(input int u);
      return (u == 0) ? busy32 : busy8;
   endfunction
   function automatic logic f_done(input int u);
      return (u == 0) ? done32 : done8;
   endfunction
   function automatic logic f_dz(input int u);
      return (u == 0) ? dz32 : dz8;
   endfunction
   function automatic logic [63:0] f_q(input int u);
      return (u == 0) ? {32'b0, q32} : {56'b0, q8};
   endfunction
   function automatic logic [63:0] f_r(input int u);
      return (u == 0) ? {32'b0, r32} : {56'b0, r8};
   endfunction

   // Reference: C-style truncating division on sign-extended 64-bit integers.
   function automatic exp_t model(input int w, input logic s, input logic [63:0] a_in,
                                  input logic [63:0] b_in);
      exp_t        e;
      logic [63:0] mask, a, b;
      longint      sa, sbv;
      mask = (64'd1 << w) - 64'd1;
      a    = a_in & mask;
      b    = b_in & mask;
      e.dz = 1'b0;
      if (b == 64'd0) begin
         e.q  = mask;
         e.r  = a;
         e.dz = 1'b1;
      end else if (s) begin
         sa   = $signed(a << (64 - w)) >>> (64 - w);
         sbv  = $signed(b << (64 - w)) >>> (64 - w);
         e.q  = 64'(sa / sbv) & mask;
         e.r  = 64'(sa % sbv) & mask;
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h want=%0h", n, act, exp);
      end
   endtask

   task automatic check_out(input int u);
      exp_t e;
      done_cnt[u]++;
      if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
         checks++;
         failures++;
         $display("FAIL unit%0d unexpected done: got=done want=no done", u);
      end else begin
         e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
         chk($sformatf("unit%0d sb quotient", u), f_q(u), e.q);
         chk($sformatf("unit%0d sb remainder", u), f_r(u), e.r);
         chk($sformatf("unit%0d sb div_by_zero", u), {63'b0, f_dz(u)}, {63'b0, e.dz});
         last_r[u] = e;
      end
   endtask

   always @(negedge clk) begin
      if (done32) check_out(0);
      if (done8) check_out(1);
   end

   task automatic go(input int u, input logic s, input logic [63:0] a, input logic [63:0] b);
      start[u] = 1'b1;
      sgn[u]   = s;
      av[u]    = a;
      bv[u]    = b;
      if (!f_busy(u) && !flush[u] && !rst[u]) begin
         if (u == 0) sb0.push_back(model(32, s, a, b));
         else        sb1.push_back(model(8, s, a, b));
      end
      @(negedge clk);
      start[u] = 1'b0;
      av[u]    = {$urandom, $urandom};
      bv[u]    = {$urandom, $urandom};
   endtask

   // Edges counted inclusively from the start-sampling edge.
   task automatic wait_done(input int u, output int edges, output int busy_cyc);
      edges    = 1;
      busy_cyc = 0;
      while (!f_done(u) && edges < 200) begin
         busy_cyc += int'(f_busy(u));
         @(negedge clk);
         edges++;
      end
      if (!f_done(u)) begin
         checks++;
         failures++;
         $display("FAIL unit%0d done timeout: got=no done want=done", u);
      end
   endtask

   task automatic div(input int u, input logic s, input logic [63:0] a, input logic [63:0] b,
                      input int lat, input logic [63:0] eq, input logic [63:0] er,
                      input logic edz, input string n);
      int e, bc;
      go(u, s, a, b);
      wait_done(u, e, bc);
      chk({n, " latency"}, 64'(e), 64'(lat));
      chk({n, " quotient"}, f_q(u), eq);
      chk({n, " remainder"}, f_r(u), er);
      chk({n, " div_by_zero"}, {63'b0, f_dz(u)}, {63'b0, edz});
   endtask

   task automatic rnd_div(input int u, input logic s, input logic [63:0] a,
                          input logic [63:0] b, input int lat);
      int e, bc;
      go(u, s, a, b);
      wait_done(u, e, bc);
      chk($sformatf("unit%0d latency %0h/%0h", u, a, b), 64'(e), 64'(lat));
   endtask

   initial begin
      int         e, bc, dc;
      logic [7:0] dl [10];
      logic [63:0] ra, rb;
      done_cnt = '{0, 0};
      rst   = 2'b11;
      start = 2'b00;
      flush = 2'b00;
      sgn   = 2'b00;
      av    = '0;
      bv    = '0;
      #2;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("unit%0d reset busy", u), {63'b0, f_busy(u)}, 64'd0);
         chk($sformatf("unit%0d reset done", u), {63'b0, f_done(u)}, 64'd0);
         chk($sformatf("unit%0d reset quotient", u), f_q(u), 64'd0);
         chk($sformatf("unit%0d reset remainder", u), f_r(u), 64'd0);
         chk($sformatf("unit%0d reset dz", u), {63'b0, f_dz(u)}, 64'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 2'b00;

      // WIDTH=32 directed
      go(0, 1'b0, 64'd100, 64'd7);
      wait_done(0, e, bc);
      chk("u32 100/7 latency", 64'(e), 64'd34);
      chk("u32 100/7 busy cycles", 64'(bc), 64'd33);
      chk("u32 100/7 quotient", f_q(0), 64'd14);
      chk("u32 100/7 remainder", f_r(0), 64'd2);
      div(0, 1'b1, 64'hFFFF_FFF9, 64'd2, 34, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 1'b0, "s32 -7/2");
      div(0, 1'b1, 64'd7, 64'hFFFF_FFFE, 34, 64'hFFFF_FFFD, 64'd1, 1'b0, "s32 7/-2");
      div(0, 1'b0, 64'd5, 64'd0, 2, 64'hFFFF_FFFF, 64'd5, 1'b1, "u32 5/0");
      div(0, 1'b0, 64'd9, 64'd3, 34, 64'd3, 64'd0, 1'b0, "u32 9/3 after zero");
      div(0, 1'b1, 64'd5, 64'd0, 2, 64'hFFFF_FFFF, 64'd5, 1'b1, "s32 5/0");
      div(0, 1'b1, 64'd9, 64'd3, 34, 64'd3, 64'd0, 1'b0, "s32 9/3 after zero");
      div(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 34, 64'h8000_0000, 64'd0, 1'b0, "s32 min/-1");
      div(0, 1'b0, 64'hFFFF_FFFF, 64'd1, 34, 64'hFFFF_FFFF, 64'd0, 1'b0, "u32 max/1");

      // start held high through RUN must not launch or queue a second division
      go(0, 1'b0, 64'd1000, 64'd10);
      repeat (8) begin
         start[0] = 1'b1;
         @(negedge clk);
      end
      start[0] = 1'b0;
      wait_done(0, e, bc);
      chk("u32 held start quotient", f_q(0), 64'd100);
      @(negedge clk);
      dc = done_cnt[0];
      repeat (40) @(negedge clk);
      chk("u32 held start extra done", 64'(done_cnt[0] - dc), 64'd0);

      // start in the done cycle
      go(0, 1'b0, 64'd12345, 64'd67);
      wait_done(0, e, bc);
      div(0, 1'b1, 64'hFFFF_FC18, 64'd33, 34, 64'hFFFF_FFE2, 64'hFFFF_FFF6, 1'b0,
          "s32 back-to-back -1000/33");

      // flush mid-RUN
      go(0, 1'b0, 64'd500, 64'd5);
      repeat (5) @(negedge clk);
      flush[0] = 1'b1;
      @(negedge clk);
      flush[0] = 1'b0;
      void'(sb0.pop_back());
      chk("u32 flush busy", {63'b0, busy32}, 64'd0);
      chk("u32 flush keeps quotient", f_q(0), last_r[0].q);
      chk("u32 flush keeps remainder", f_r(0), last_r[0].r);
      dc = done_cnt[0];
      repeat (40) @(negedge clk);
      chk("u32 flush no done", 64'(done_cnt[0] - dc), 64'd0);
      flush[0] = 1'b1;
      go(0, 1'b0, 64'd50, 64'd5);
      flush[0] = 1'b0;
      chk("u32 flush beats start", {63'b0, busy32}, 64'd0);

      // asynchronous reset mid-RUN
      go(0, 1'b0, 64'd777, 64'd3);
      repeat (5) @(negedge clk);
      dc = done_cnt[0];
      #2 rst[0] = 1'b1;
      #1;
      chk("u32 rst busy", {63'b0, busy32}, 64'd0);
      chk("u32 rst done", {63'b0, done32}, 64'd0);
      chk("u32 rst quotient", f_q(0), 64'd0);
      chk("u32 rst remainder", f_r(0), 64'd0);
      chk("u32 rst dz", {63'b0, dz32}, 64'd0);
      void'(sb0.pop_back());
      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      chk("u32 rst no done", 64'(done_cnt[0] - dc), 64'd0);
      div(0, 1'b0, 64'd9, 64'd3, 34, 64'd3, 64'd0, 1'b0, "u32 first after rst");

      repeat (40) begin
         ra = {32'b0, $urandom};
         case ($urandom_range(0, 9))
            0:       rb = 64'd0;
            1:       rb = 64'($urandom_range(1, 15));
            2:       rb = 64'hFFFF_FFFF;
            default: rb = {32'b0, $urandom};
         endcase
         rnd_div(0, 1'($urandom), ra, rb, (rb == 64'd0) ? 2 : 34);
      end

      // WIDTH=8 directed
      go(1, 1'b0, 64'd100, 64'd7);
      wait_done(1, e, bc);
      chk("u8 100/7 latency", 64'(e), 64'd10);
      chk("u8 100/7 busy cycles", 64'(bc), 64'd9);
      div(1, 1'b1, 64'hF9, 64'd2, 10, 64'hFD, 64'hFF, 1'b0, "s8 -7/2");
      div(1, 1'b1, 64'h80, 64'hFF, 10, 64'h80, 64'd0, 1'b0, "s8 min/-1");
      div(1, 1'b1, 64'd5, 64'd0, 2, 64'hFF, 64'd5, 1'b1, "s8 5/0");
      div(1, 1'b0, 64'hFF, 64'd1, 10, 64'hFF, 64'd0, 1'b0, "u8 max/1");

      // WIDTH=8 sweep: every divisor against a spread of dividends, both modes
      dl = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00};
      dl[9] = 8'($urandom);
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 256; b++) begin
               rnd_div(1, 1'(s), 64'(dl[i]), 64'(b), (b == 0) ? 2 : 10);
            end
         end
      end

      repeat (3) @(negedge clk);
      chk("u32 scoreboard drained", 64'(sb0.size()), 64'd0);
      chk("u8 scoreboard drained", 64'(sb1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
